window_loader: RTL and testbench
================================

WINDOW_LOADER -- requirements
Module: window_loader

Interface
REQ-001 SHALL have parameter PIX_W, default 8, meaning bits per integer pixel.
REQ-002 SHALL have parameter DIM, default 15, meaning window side length in pixels (window = DIM x DIM).
REQ-003 SHALL have port clock  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port pix_in  input  PIX_W  pixel data, raster order (row 0 col 0 first).
REQ-006 SHALL have port pix_valid  input  1  pix_in valid this cycle.
REQ-007 SHALL have port pix_sof  input  1  marks first pixel of a window; qualified by pix_valid.
REQ-008 SHALL have port pix_ready  output  1  loader accepts a pixel this cycle.
REQ-009 SHALL have port integer_array  output  DIM*DIM*PIX_W (1800)  assembled window.
REQ-010 SHALL have port window_valid  output  1  integer_array complete and stable.
REQ-011 SHALL have port window_ack  input  1  consumer has finished with the window.
REQ-012 SHALL have port pixel_count  output  8  pixels accepted in the current window (0..225).
REQ-013 SHALL have port sof_err  output  1  one-cycle pulse on resynchronising pix_sof.

Function
REQ-014 SHALL transfer a pixel only on a rising edge where pix_valid and pix_ready are both 1.
REQ-015 SHALL write the pixel at row r, column c to integer_array[PIX_W*(c + DIM*r) +: PIX_W], so row r occupies bits [120r +: 120].
REQ-016 SHALL keep row counter r and column counter c; c increments per accepted pixel, wraps at DIM-1 to 0 while r increments.
REQ-017 SHALL implement two states: FILL (pix_ready=1, window_valid=0) and FULL (pix_ready=0, window_valid=1).
REQ-018 SHALL move FILL->FULL on the edge accepting pixel r=DIM-1, c=DIM-1; window_valid high the next cycle (1-cycle latency).
REQ-019 SHALL hold integer_array unchanged throughout FULL.
REQ-020 SHALL move FULL->FILL on the edge where window_ack=1, clearing r, c and pixel_count; integer_array retains old contents until overwritten.
REQ-021 SHALL ignore window_ack in FILL.
REQ-022 SHALL, when a pixel with pix_sof=1 is accepted, write it to r=0,c=0 and set the next position to c=1 regardless of prior count.
REQ-023 SHALL pulse sof_err for one cycle when the accepted pix_sof pixel arrives with pixel_count != 0; no pulse when pixel_count = 0.
REQ-024 SHALL accept a pixel without pix_sof at pixel_count = 0 as position (0,0) (sof optional at window start).
REQ-025 SHALL, in FULL with pix_valid=1 and window_ack=1 on the same edge, not accept the pixel (pix_ready is 0); it is accepted in FILL the following cycle.
REQ-026 SHALL drive pix_ready combinationally from state only, with no dependence on pix_valid.
REQ-027 SHALL make pixel_count equal to DIM*r + c in FILL and DIM*DIM (225) in FULL.

Reset
REQ-028 SHALL, while reset=1, force state FILL, r=c=0, pixel_count=0, integer_array all zeros, window_valid=0, sof_err=0, pix_ready=0.
REQ-029 SHALL assert pix_ready=1 on the first cycle after reset deasserts.
REQ-030 SHALL abandon a partial window on reset mid-fill; no window_valid for the discarded pixels.

Verification
REQ-031 Stream 225 pixels value 0..224 continuous valid with sof on first -> window_valid=1 one cycle after last, byte k of integer_array = k, pix_ready=0.
REQ-032 Random pix_valid gaps over 225 pixels -> same array as REQ-031; pixel_count monotonic, no pixel lost or duplicated.
REQ-033 Hold FULL 20 cycles with pix_valid=1 -> integer_array unchanged, no transfer; assert window_ack -> pix_ready=1 next cycle, pixel_count=0.
REQ-034 Send 50 pixels, then pix_sof pixel 0xAA -> sof_err one-cycle pulse, byte 0 = 0xAA, pixel_count=1; 224 more pixels -> window_valid.
REQ-035 Assert reset after 100 pixels -> all outputs to reset values immediately; 225 fresh pixels load correctly.
REQ-036 window_ack pulsed during FILL -> no effect on counters or state.

Source files
------------

// File: rtl/window_loader.sv
// Assembles a DIM x DIM window of PIX_W-bit pixels from a raster-order stream
// and holds it for a downstream consumer until it is acknowledged.
module window_loader #(
  parameter int PIX_W = 8,
  parameter int DIM   = 15
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [PIX_W-1:0]         pix_in,
  input  logic                     pix_valid,
  input  logic                     pix_sof,
  output logic                     pix_ready,
  output logic [DIM*DIM*PIX_W-1:0] integer_array,
  output logic                     window_valid,
  input  logic                     window_ack,
  output logic [7:0]               pixel_count,
  output logic                     sof_err
);

  localparam int RW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int AW = $clog2(DIM * DIM * PIX_W);
  localparam logic [RW-1:0] LAST_POS   = RW'(DIM - 1);
  localparam logic [7:0]    FULL_COUNT = 8'(DIM * DIM);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t                     state_r, state_nxt_s;
  logic [RW-1:0]              row_r, col_r, row_nxt_s, col_nxt_s;
  logic [RW-1:0]              cur_row_s, cur_col_s;
  logic [7:0]                 count_r, count_nxt_s, cur_count_s;
  logic                       sof_err_r, sof_err_nxt_s;
  logic                       accept_s;
  logic [AW-1:0]              wr_off_s;
  logic [DIM*DIM*PIX_W-1:0]   array_r;

  // Ready depends on state only; reset holds it low even though state is FILL.
  assign pix_ready     = (state_r == FILL) && !reset;
  assign accept_s      = pix_ready && pix_valid;
  assign integer_array = array_r;
  assign window_valid  = (state_r == FULL);
  assign pixel_count   = count_r;
  assign sof_err       = sof_err_r;

  // Next-state, write position and counter update.
  always_comb begin
    state_nxt_s   = state_r;
    row_nxt_s     = row_r;
    col_nxt_s     = col_r;
    count_nxt_s   = count_r;
    sof_err_nxt_s = 1'b0;
    // A start-of-frame pixel always lands at (0,0), whatever was loaded before.
    if (pix_sof) begin
      cur_row_s   = '0;
      cur_col_s   = '0;
      cur_count_s = 8'd0;
    end else begin
      cur_row_s   = row_r;
      cur_col_s   = col_r;
      cur_count_s = count_r;
    end
    wr_off_s = AW'(PIX_W) * (AW'(cur_col_s) + AW'(DIM) * AW'(cur_row_s));
    case (state_r)
      FILL: begin
        if (accept_s) begin
          sof_err_nxt_s = pix_sof && (count_r != 8'd0);
          if ((cur_row_s == LAST_POS) && (cur_col_s == LAST_POS)) begin
            state_nxt_s = FULL;
            row_nxt_s   = '0;
            col_nxt_s   = '0;
            count_nxt_s = FULL_COUNT;
          end else if (cur_col_s == LAST_POS) begin
            row_nxt_s   = cur_row_s + RW'(1);
            col_nxt_s   = '0;
            count_nxt_s = cur_count_s + 8'd1;
          end else begin
            row_nxt_s   = cur_row_s;
            col_nxt_s   = cur_col_s + RW'(1);
            count_nxt_s = cur_count_s + 8'd1;
          end
        end else begin
          state_nxt_s = FILL;
        end
      end
      FULL: begin
        if (window_ack) begin
          state_nxt_s = FILL;
          row_nxt_s   = '0;
          col_nxt_s   = '0;
          count_nxt_s = 8'd0;
        end else begin
          state_nxt_s = FULL;
        end
      end
      default: begin
        state_nxt_s = FILL;
        row_nxt_s   = '0;
        col_nxt_s   = '0;
        count_nxt_s = 8'd0;
      end
    endcase
  end

  // State, position counters and error pulse registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= FILL;
      row_r     <= '0;
      col_r     <= '0;
      count_r   <= 8'd0;
      sof_err_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      row_r     <= row_nxt_s;
      col_r     <= col_nxt_s;
      count_r   <= count_nxt_s;
      sof_err_r <= sof_err_nxt_s;
    end
  end

  // Window storage; only written by accepted pixels, so it is frozen in FULL.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      array_r <= '0;
    end else if (accept_s) begin
      array_r[wr_off_s +: PIX_W] <= pix_in;
    end else begin
      array_r <= array_r;
    end
  end

endmodule

// File: tb/tb_window_loader.sv
// Randomised bench for window_loader against a linear-index reference model.
module tb_window_loader;

  localparam int PIX_W = 8;
  localparam int DIM   = 15;
  localparam int N     = DIM * DIM;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic [PIX_W-1:0]   pix_in = '0;
  logic               pix_valid = 1'b0;
  logic               pix_sof = 1'b0;
  logic               window_ack = 1'b0;
  logic               pix_ready;
  logic               window_valid;
  logic               sof_err;
  logic [N*PIX_W-1:0] integer_array;
  logic [7:0]         pixel_count;

  int total = 0;
  int bad   = 0;

  // Reference model: flat byte array, pixels-loaded count, full flag.
  logic [7:0] mem [N];
  int         cnt;
  bit         full;
  bit         exp_sof;

  window_loader #(.PIX_W(PIX_W), .DIM(DIM)) dut (
    .clock(clock), .reset(reset), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_sof(pix_sof), .pix_ready(pix_ready), .integer_array(integer_array),
    .window_valid(window_valid), .window_ack(window_ack),
    .pixel_count(pixel_count), .sof_err(sof_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] fold(input logic [N*PIX_W-1:0] v);
    logic [31:0] h;
    h = 32'd0;
    for (int i = 0; i < N; i++) h = h * 32'd31 + {24'd0, v[8*i +: 8]};
    return h;
  endfunction

  function automatic logic [N*PIX_W-1:0] pack_mem();
    logic [N*PIX_W-1:0] v;
    for (int i = 0; i < N; i++) v[8*i +: 8] = mem[i];
    return v;
  endfunction

  task automatic check_outputs();
    chk("pix_ready",    32'(pix_ready),    32'(!full && !reset));
    chk("window_valid", 32'(window_valid), 32'(full));
    chk("pixel_count",  32'(pixel_count),  full ? 32'(N) : 32'(cnt));
    chk("sof_err",      32'(sof_err),      32'(exp_sof));
    chk("array_fold",   fold(integer_array), fold(pack_mem()));
  endtask

  task automatic check_bytes();
    for (int i = 0; i < N; i++) chk("array_byte", 32'(integer_array[8*i +: 8]), 32'(mem[i]));
  endtask

  // One clock: drive inputs, advance the model at the edge, compare after it.
  task automatic step(input bit v, input bit s, input bit a, input logic [7:0] p);
    pix_valid  = v;
    pix_sof    = s;
    window_ack = a;
    pix_in     = p;
    @(posedge clock);
    exp_sof = 1'b0;
    if (!full) begin
      if (v) begin
        int pos;
        pos = s ? 0 : cnt;
        exp_sof = s && (cnt != 0);
        mem[pos] = p;
        cnt = pos + 1;
        if (cnt == N) full = 1'b1;
      end
    end else if (a) begin
      full = 1'b0;
      cnt  = 0;
    end
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    pix_valid  = 1'b0;
    pix_sof    = 1'b0;
    window_ack = 1'b0;
    #1;
    full = 1'b0;
    cnt  = 0;
    exp_sof = 1'b0;
    for (int i = 0; i < N; i++) mem[i] = 8'd0;
    check_outputs();
    repeat (2) begin
      @(posedge clock);
      #1;
      check_outputs();
    end
    reset = 1'b0;
    #1;
    check_outputs();
  endtask

  // Feed n accepted pixels; optional valid gaps and random FILL-time acks.
  task automatic feed(input int n, input int base, input bit sof_first, input bit gaps, input bit rnd);
    int acc;
    int guard;
    bit v;
    bit a;
    logic [7:0] p;
    acc = 0;
    guard = 0;
    while (acc < n && guard < 5000) begin
      v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      a = gaps ? ($urandom_range(0, 3) == 0) : 1'b0;
      p = rnd ? 8'($urandom) : 8'(base + acc);
      if (v && !full) begin
        step(v, sof_first && (acc == 0), a, p);
        acc++;
      end else begin
        step(v, 1'b0, a, p);
      end
      guard++;
    end
    chk("feed_count", 32'(acc), 32'(n));
  endtask

  initial begin
    do_reset();

    // Full window with continuous valid and sof on the first pixel.
    feed(N, 0, 1'b1, 1'b0, 1'b0);
    check_bytes();
    chk("seq_byte100", 32'(integer_array[8*100 +: 8]), 32'd100);
    chk("seq_byte224", 32'(integer_array[8*224 +: 8]), 32'd224);

    // Hold in FULL with valid asserted, then ack together with a valid pixel.
    repeat (20) step(1'b1, 1'b0, 1'b0, 8'($urandom));
    step(1'b1, 1'b0, 1'b1, 8'h55);
    chk("ack_count", 32'(pixel_count), 32'd0);
    step(1'b1, 1'b0, 1'b0, 8'h66);
    chk("after_ack_byte0", 32'(integer_array[7:0]), 32'h66);
    feed(N - 1, 1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h00);

    // Random gaps and FILL-time acks.
    feed(N, 0, 1'b1, 1'b1, 1'b0);
    check_bytes();
    step(1'b0, 1'b0, 1'b1, 8'h00);

    // Resynchronising sof after 50 pixels.
    feed(50, 0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 8'hAA);
    chk("resync_byte0", 32'(integer_array[7:0]), 32'hAA);
    chk("resync_count", 32'(pixel_count), 32'd1);
    chk("resync_err", 32'(sof_err), 32'd1);
    feed(N - 1, 0, 1'b0, 1'b0, 1'b1);
    chk("resync_full", 32'(window_valid), 32'd1);
    step(1'b0, 1'b0, 1'b1, 8'h00);

    // Reset mid-fill, then a fresh window without sof.
    feed(100, 0, 1'b1, 1'b0, 1'b1);
    do_reset();
    feed(N, 0, 1'b0, 1'b0, 1'b1);
    check_bytes();
    step(1'b0, 1'b0, 1'b1, 8'h00);

    // Unconstrained random traffic.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 3) == 0, 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
